circuit: RTL and testbench

- Free-running Fibonacci sequence generator with enable.
- Each enabled clock advances the output `f` one term: 0, 1, 1, 2, 3, 5, 8, …
- Standalone leaf block used as a demo/regression target for wide-adder timing and simulation.
- All arithmetic is unsigned, modulo 2^W.

---
 rtl/circuit_pkg.sv | 7 +
 rtl/circuit_if.sv | 12 +
 rtl/circuit_fib_step.sv | 14 +
 rtl/circuit.sv | 38 +++
 tb/tb_circuit.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/circuit_pkg.sv
// Shared constants for the Fibonacci generator: the two seed terms loaded at reset.
package circuit_pkg;

  localparam int unsigned FIB_F0 = 0;
  localparam int unsigned FIB_F1 = 1;

endpackage

// File: rtl/circuit_if.sv
// Enable in, current term out; master drives en, slave (the generator) drives f.
interface circuit_if #(
  parameter int W = 128
);

  logic         en;
  logic [W-1:0] f;

  modport master (output en, input f);
  modport slave  (input en, output f);

endinterface

// File: rtl/circuit_fib_step.sv
// Combinational next-state of the sequence: (a, b) -> (b, a + b) mod 2^W; zero latency, no flow control.
module circuit_fib_step #(
  parameter int W = 128
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_a_next,
  output logic [W-1:0] o_b_next
);

  assign o_a_next = i_b;
  assign o_b_next = i_a + i_b;

endmodule

// File: rtl/circuit.sv
// Free-running Fibonacci generator; f = F(k) mod 2^W after k enabled edges.
// Output registered, updates on the edge sampling en=1; en=0 simply holds state.
module circuit
  import circuit_pkg::*;
#(
  parameter int W = 128
) (
  input  logic       clk,
  input  logic       rst,
  circuit_if.slave   bus
);

  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] w_a_next;
  logic [W-1:0] w_b_next;

  circuit_fib_step #(.W(W)) u_step (
    .i_a      (r_a),
    .i_b      (r_b),
    .o_a_next (w_a_next),
    .o_b_next (w_b_next)
  );

  // b runs one term ahead of a, so it wraps one step earlier; both stay consistent mod 2^W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a <= W'(FIB_F0);
      r_b <= W'(FIB_F1);
    end else if (bus.en) begin
      r_a <= w_a_next;
      r_b <= w_b_next;
    end
  end

  assign bus.f = r_a;

endmodule

// File: tb/tb_circuit.sv
// Directed bench for circuit at W=128 and W=8 driven in lockstep from a shared enable/reset.
module tb_circuit;

  logic clk;
  logic rst;
  logic en;

  int n_checks;
  int n_errors;

  logic [127:0] m_a;
  logic [127:0] m_b;

  circuit_if #(.W(128)) if_w128 ();
  circuit_if #(.W(8))   if_w8 ();

  assign if_w128.en = en;
  assign if_w8.en   = en;

  circuit #(.W(128)) dut_w128 (
    .clk (clk),
    .rst (rst),
    .bus (if_w128.slave)
  );

  circuit #(.W(8)) dut_w8 (
    .clk (clk),
    .rst (rst),
    .bus (if_w8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: reference state follows the inputs seen at the rising edge; returns at the falling edge.
  task automatic tick();
    logic [127:0] t;
    @(posedge clk);
    if (!rst) begin
      m_a = 128'd0;
      m_b = 128'd1;
    end else if (en) begin
      t   = m_a + m_b;
      m_a = m_b;
      m_b = t;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  logic [127:0] seq10 [10];

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_a = 128'd0;
    m_b = 128'd1;
    seq10 = '{128'd1, 128'd1, 128'd2, 128'd3, 128'd5,
              128'd8, 128'd13, 128'd21, 128'd34, 128'd55};
    rst = 1'b0;
    en  = 1'b0;
    #1;
    chk("reset_initial_w128", if_w128.f, 128'd0);

    // Reset held with en toggling
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      en = i[0];
      tick();
      chk("reset_hold_w128", if_w128.f, 128'd0);
      chk("reset_hold_w8", {120'd0, if_w8.f}, 128'd0);
    end
    en  = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("release_en0_w128", if_w128.f, 128'd0);

    // Basic sequence
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("seq_w128", if_w128.f, seq10[i]);
      chk("seq_w8", {120'd0, if_w8.f}, seq10[i]);
    end
    for (int i = 10; i < 100; i++) tick();
    chk("f100_w128", if_w128.f, 128'd354224848179261915075);

    // Enable gating
    en = 1'b0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("gate_pre_w128", if_w128.f, 128'd13);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("gate_hold_w128", if_w128.f, 128'd13);
    end
    en = 1'b1;
    tick();
    chk("gate_resume1_w128", if_w128.f, 128'd21);
    tick();
    chk("gate_resume2_w128", if_w128.f, 128'd34);
    tick();
    tick();
    chk("pre_async_w128", if_w128.f, 128'd89);
    chk("pre_async_w8", {120'd0, if_w8.f}, 128'd89);

    // Async reset between edges
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_w128", if_w128.f, 128'd0);
    chk("async_rst_w8", {120'd0, if_w8.f}, 128'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("post_async_w128", if_w128.f, 128'd2);

    // Wrap-around on the narrow instance
    do_reset();
    for (int i = 0; i < 14; i++) tick();
    chk("wrap14_w8", {120'd0, if_w8.f}, 128'd121);
    chk("k14_w128", if_w128.f, 128'd377);
    tick();
    chk("wrap15_w8", {120'd0, if_w8.f}, 128'd98);
    chk("k15_w128", if_w128.f, 128'd610);

    // Random enable pattern against the reference
    en = 1'b0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      en = 1'($urandom_range(0, 1));
      tick();
      chk("rand_w128", if_w128.f, m_a);
      chk("rand_w8", {120'd0, if_w8.f}, {120'd0, m_a[7:0]});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
